// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous signal in clock_in cycles,
// and flags the signal as absent when no rising edge arrives within TIMEOUT cycles.
`timescale 1ns/1ps
module clk_period_meter #(
  parameter int unsigned       WIDTH   = 28,
  parameter logic [WIDTH-1:0]  TIMEOUT = 28'd100_000_000
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period_out,
  output logic [WIDTH-1:0] high_out,
  output logic             meas_valid,
  output logic             no_clock
);

  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] TO_LAST = TIMEOUT - ONE;

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state_q;
  logic             s1_q, s2_q, s3_q;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hcnt_q, hcnt_d;
  logic [WIDTH-1:0] period_q, high_q;
  logic             valid_q, noclk_q;
  logic             rise, timeout;

  // A rise on the last count wins over the timeout.
  always_comb begin
    rise    = s2_q & ~s3_q;
    timeout = ~rise & (cnt_q == TO_LAST);
    cnt_d   = (rise | timeout) ? '0 : cnt_q + ONE;
    hcnt_d  = hcnt_q;
    if (rise)
      hcnt_d = ONE;
    else if (s2_q)
      hcnt_d = hcnt_q + ONE;
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      cnt_q  <= '0;
      hcnt_q <= '0;
    end else begin
      s1_q   <= sig_in;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      cnt_q  <= cnt_d;
      hcnt_q <= hcnt_d;
    end
  end

  // The first edge after reset or timeout only arms; later edges report.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      noclk_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (timeout) begin
        state_q  <= IDLE;
        noclk_q  <= 1'b1;
        period_q <= '0;
        high_q   <= '0;
      end else if (rise) begin
        case (state_q)
          IDLE: state_q <= MEASURE;
          MEASURE: begin
            period_q <= cnt_q + ONE;
            high_q   <= hcnt_q;
            valid_q  <= 1'b1;
            noclk_q  <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign period_out = period_q;
  assign high_out   = high_q;
  assign meas_valid = valid_q;
  assign no_clock   = noclk_q;

endmodule
